// File: rtl/eight_way_distributor_pkg.sv
// Shared defaults and lane state encoding for the eight-way write distributor.
package eight_way_distributor_pkg;

    localparam int DIST_WIDTH = 16;
    localparam int DIST_LANES = 8;
    localparam int DIST_SEL_W = 3;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/eight_way_distributor_lane.sv
// One lane holding register: word captured on write, held until ack; 1-cycle write latency.
// A same-cycle ack and write keeps the lane full with the new word; ack on an empty lane is ignored.
module distributor_lane
    import eight_way_distributor_pkg::*;
#(
    parameter int WIDTH = DIST_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    lane_state_t state;
    lane_state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LANE_EMPTY;
            data  <= '0;
        end else begin
            state <= state_next;
            if (wr) begin
                data <= din;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LANE_EMPTY: begin
                if (wr) begin
                    state_next = LANE_FULL;
                end
            end
            LANE_FULL: begin
                // Data is left in place on drain; only the valid state clears.
                if (ack && !wr) begin
                    state_next = LANE_EMPTY;
                end
            end
            default: state_next = LANE_EMPTY;
        endcase
    end

    assign valid = (state == LANE_FULL);

endmodule

// File: rtl/eight_way_distributor.sv
// Steers one word per cycle into one of eight lane registers (sel or round-robin); 1-cycle latency.
// in_ready drops when the target lane is full and not being acked; auto mode stalls rather than skipping.
module eight_way_distributor
    import eight_way_distributor_pkg::*;
#(
    parameter int WIDTH = DIST_WIDTH,
    parameter int LANES = DIST_LANES,
    parameter int SEL_W = DIST_SEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   auto_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ack,
    output logic [SEL_W:0]         occupancy,
    output logic                   all_full
);

    localparam int CW = SEL_W + 1;

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] target;
    logic             accept;
    logic [LANES-1:0] wr_vec;
    logic [LANES-1:0] drop_vec;
    logic [CW-1:0]    drops;
    logic [CW-1:0]    occ_next;

    always_comb begin
        target   = auto_mode ? rr_ptr : sel;
        in_ready = !out_valid[target] || out_ack[target];
        accept   = in_valid && in_ready;

        wr_vec = '0;
        if (accept) begin
            wr_vec[target] = 1'b1;
        end

        // A lane acked and rewritten in the same cycle stays occupied.
        drop_vec = out_valid & out_ack & ~wr_vec;
        drops    = '0;
        for (int k = 0; k < LANES; k++) begin
            drops = drops + CW'(drop_vec[k]);
        end

        occ_next = occupancy + CW'(accept && !out_valid[target]) - drops;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            occupancy <= '0;
            all_full  <= 1'b0;
        end else begin
            if (accept && auto_mode) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
            occupancy <= occ_next;
            all_full  <= (occ_next == CW'(LANES));
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        distributor_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr    (wr_vec[k]),
            .din   (din),
            .ack   (out_ack[k]),
            .data  (out_data[k*WIDTH +: WIDTH]),
            .valid (out_valid[k])
        );
    end

endmodule

// File: tb/tb_eight_way_distributor.sv
// Directed scenarios followed by random traffic, checked against an array-based lane model.
module tb_eight_way_distributor;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  din;
    logic [2:0]   sel;
    logic         auto_mode;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ack;
    logic [3:0]   occupancy;
    logic         all_full;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdata [8];
    bit          mvalid [8];
    int          mrr;

    always #5 clk = ~clk;

    eight_way_distributor dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sel       (sel),
        .auto_mode (auto_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .occupancy (occupancy),
        .all_full  (all_full)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            mdata[k]  = '0;
            mvalid[k] = 1'b0;
        end
        mrr = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [127:0] exp_data;
        logic [7:0]   exp_valid;
        int           cnt;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            exp_data[k*16 +: 16] = mdata[k];
            exp_valid[k]         = mvalid[k];
            if (mvalid[k]) cnt++;
        end
        check({tag, ".data"}, out_data, exp_data);
        check({tag, ".valid"}, out_valid, exp_valid);
        check({tag, ".occ"}, occupancy, cnt);
        check({tag, ".full"}, all_full, cnt == 8);
    endtask

    // Drives one cycle of inputs, checks in_ready before the edge and state after it.
    task automatic step(input string tag, input logic [15:0] d, input logic [2:0] s,
                        input logic a, input logic v, input logic [7:0] ack);
        int t;
        bit rdy;
        din       = d;
        sel       = s;
        auto_mode = a;
        in_valid  = v;
        out_ack   = ack;
        #1;
        t   = a ? mrr : int'(s);
        rdy = !mvalid[t] || ack[t];
        check({tag, ".rdy"}, in_ready, rdy);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (ack[k]) mvalid[k] = 1'b0;
        end
        if (v && rdy) begin
            mdata[t]  = d;
            mvalid[t] = 1'b1;
            if (a) mrr = (mrr + 1) % 8;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ack  = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] vals [8];
        vals = '{16'd50, 16'd100, 16'd5000, 16'd10000, 16'd12, 16'd2, 16'd9000, 16'd1234};

        rst = 1'b1; din = '0; sel = '0; auto_mode = 1'b0; in_valid = 1'b0; out_ack = '0;
        model_reset();
        #1;
        check("rst.valid", out_valid, 8'h00);
        check("rst.data", out_data, 128'h0);
        check("rst.occ", occupancy, 4'd0);
        check("rst.full", all_full, 1'b0);
        check("rst.rdy", in_ready, 1'b1);
        #2;
        rst = 1'b0;

        // 1: fill all lanes by select
        for (int k = 0; k < 8; k++) step("fill", vals[k], 3'(k), 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 8; k++) check("fill.lane", out_data[k*16 +: 16], vals[k]);
        check("fill.valid", out_valid, 8'hFF);
        check("fill.occ", occupancy, 4'd8);
        check("fill.full", all_full, 1'b1);

        // 2: stall on full lane 3, then ack+write replaces it
        step("stall", 16'd7, 3'd3, 1'b0, 1'b1, 8'h00);
        check("stall.rdy0", in_ready, 1'b0);
        check("stall.lane3", out_data[48 +: 16], 16'd10000);
        step("ackwr", 16'd7, 3'd3, 1'b0, 1'b1, 8'h08);
        check("ackwr.lane3", out_data[48 +: 16], 16'd7);
        check("ackwr.v3", out_valid[3], 1'b1);
        check("ackwr.occ", occupancy, 4'd8);

        // 3: round-robin with all lanes acked each cycle
        do_reset();
        for (int i = 1; i <= 10; i++) step("rr", 16'(i), 3'd0, 1'b1, 1'b1, 8'hFF);
        check("rr.ptr", dut.rr_ptr, 3'd2);
        check("rr.lane0", out_data[0 +: 16], 16'd9);
        check("rr.lane1", out_data[16 +: 16], 16'd10);
        check("rr.lane7", out_data[112 +: 16], 16'd8);

        // 4: auto mode stalls on full lane 0 without skipping
        do_reset();
        step("a4.pre", 16'hAAAA, 3'd0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step("a4.stall", 16'h5555, 3'd4, 1'b1, 1'b1, 8'h00);
        check("a4.lane1", out_valid[1], 1'b0);
        check("a4.lane0", out_data[0 +: 16], 16'hAAAA);
        step("a4.ack", 16'h5555, 3'd4, 1'b1, 1'b1, 8'h01);
        check("a4.lane0new", out_data[0 +: 16], 16'h5555);
        check("a4.v1", out_valid[1], 1'b0);

        // 5: asynchronous reset between edges
        step("a5.w", 16'h1111, 3'd0, 1'b1, 1'b1, 8'h00);
        step("a5.w", 16'h2222, 3'd0, 1'b1, 1'b1, 8'h00);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("arst.valid", out_valid, 8'h00);
        check("arst.data", out_data, 128'h0);
        check("arst.occ", occupancy, 4'd0);
        check("arst.full", all_full, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("a5.first", 16'h3333, 3'd6, 1'b1, 1'b1, 8'h00);
        check("a5.lane0", out_data[0 +: 16], 16'h3333);
        check("a5.v", out_valid, 8'h01);

        // 6: ack to empty lane 5 with a write to lane 2
        do_reset();
        step("a6", 16'h0BEE, 3'd2, 1'b0, 1'b1, 8'h20);
        check("a6.valid", out_valid, 8'h04);
        check("a6.occ", occupancy, 4'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 16'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0), 8'($urandom & $urandom & $urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
